// File: rtl/bus_pkg.sv
// Shared definitions for the single-wire node bus: FSM states, frame field widths
// and the serial CRC-4 (x^4+x+1) update used by both the transmitter and the receiver.
package bus_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_SOF,
      ST_ADDR,
      ST_DATA,
      ST_CRC,
      ST_ACK,
      ST_EOF
   } state_t;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 64;
   localparam int CRC_W  = 4;

   localparam logic [CRC_W-1:0] CRC_POLY = 4'b0011;

   function automatic logic [CRC_W-1:0] crc4_update(input logic [CRC_W-1:0] crc,
                                                    input logic             din);
      logic fb;
      fb = crc[CRC_W-1] ^ din;
      return {crc[CRC_W-2:0], 1'b0} ^ (fb ? CRC_POLY : '0);
   endfunction

endpackage

// File: rtl/bus_bit_timer.sv
// Bus line synchroniser, falling-edge detector and per-bit cycle counter.
// o_sample strobes at cycle BIT_CYCLES/2 of every bit, counted from the SOF edge.
module bus_bit_timer #(
   parameter int BIT_CYCLES = 4
) (
   input  logic i_clock,
   input  logic i_reset_n,
   input  logic i_bus,
   input  logic i_run,
   output logic o_line,
   output logic o_fall,
   output logic o_sample
);

   localparam logic [7:0] CNT_LAST = 8'(BIT_CYCLES - 1);
   localparam logic [7:0] CNT_SMP  = 8'(BIT_CYCLES / 2);

   logic       r_sync1;
   logic       r_sync2;
   logic       r_prev;
   logic [7:0] r_cnt;
   logic       w_fall;

   assign w_fall   = r_prev & ~r_sync2;
   assign o_line   = r_sync2;
   assign o_fall   = w_fall;
   assign o_sample = i_run && (r_cnt == CNT_SMP);

   always_ff @(posedge i_clock or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_sync1 <= 1'b1;
         r_sync2 <= 1'b1;
         r_prev  <= 1'b1;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_bus;
         r_sync2 <= r_sync1;
         r_prev  <= r_sync2;
         // The edge cycle itself is cycle 0 of the SOF bit, so the next cycle is 1.
         if (!i_run)
            r_cnt <= w_fall ? 8'd1 : 8'd0;
         else if (r_cnt == CNT_LAST)
            r_cnt <= '0;
         else
            r_cnt <= r_cnt + 8'd1;
      end
   end

endmodule

// File: rtl/bus_receiver.sv
// Single-wire bus frame receiver: SOF, ADDR, DATA, CRC-4, [ACK], EOF.
// Define BUS_RX_ACK_EN to add the ACK slot, driven low for good addressed frames.
module bus_receiver
   import bus_pkg::*;
#(
   parameter int         BIT_CYCLES = 4,
   parameter logic [3:0] BCAST_ADDR = 4'hF
) (
   input  logic                clock,
   input  logic                reset_n,
   input  logic [ADDR_W-1:0]   my_addr,
   inout  wire                 bus,
   output logic [ADDR_W-1:0]   rx_addr,
   output logic [DATA_W-1:0]   rx_data,
   output logic                rx_valid,
   output logic                crc_err,
   output logic                frm_err,
   output logic                busy
);

   localparam logic [6:0] ADDR_LAST = 7'(ADDR_W - 1);
   localparam logic [6:0] DATA_LAST = 7'(DATA_W - 1);
   localparam logic [6:0] CRC_LAST  = 7'(CRC_W - 1);

   state_t              r_state;
   state_t              w_next;
   logic [6:0]          r_bitcnt;
   logic [ADDR_W-1:0]   r_addr;
   logic [DATA_W-1:0]   r_data;
   logic [CRC_W-1:0]    r_crc_rx;
   logic [CRC_W-1:0]    r_crc_calc;
   logic                r_match;
   logic                r_rx_valid;
   logic                r_crc_err;
   logic                r_frm_err;
   logic                w_line;
   logic                w_fall;
   logic                w_sample;
   logic                w_busy;
   logic [ADDR_W-1:0]   w_addr_nx;

   assign w_busy    = (r_state != ST_IDLE);
   assign w_addr_nx = {r_addr[ADDR_W-2:0], w_line};

   bus_bit_timer #(
      .BIT_CYCLES (BIT_CYCLES)
   ) u_timer (
      .i_clock   (clock),
      .i_reset_n (reset_n),
      .i_bus     (bus),
      .i_run     (w_busy),
      .o_line    (w_line),
      .o_fall    (w_fall),
      .o_sample  (w_sample)
   );

   always_comb begin
      w_next = r_state;
      case (r_state)
         ST_IDLE: if (w_fall) w_next = ST_SOF;
         ST_SOF:  if (w_sample) w_next = w_line ? ST_IDLE : ST_ADDR;
         ST_ADDR: if (w_sample && r_bitcnt == ADDR_LAST) w_next = ST_DATA;
         ST_DATA: if (w_sample && r_bitcnt == DATA_LAST) w_next = ST_CRC;
`ifdef BUS_RX_ACK_EN
         ST_CRC:  if (w_sample && r_bitcnt == CRC_LAST) w_next = ST_ACK;
         ST_ACK:  if (w_sample) w_next = ST_EOF;
`else
         ST_CRC:  if (w_sample && r_bitcnt == CRC_LAST) w_next = ST_EOF;
`endif
         ST_EOF:  if (w_sample) w_next = ST_IDLE;
         default: w_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state    <= ST_IDLE;
         r_bitcnt   <= '0;
         r_rx_valid <= 1'b0;
         r_crc_err  <= 1'b0;
         r_frm_err  <= 1'b0;
         rx_addr    <= '0;
         rx_data    <= '0;
      end else begin
         r_state    <= w_next;
         r_rx_valid <= 1'b0;
         r_crc_err  <= 1'b0;
         r_frm_err  <= 1'b0;
         if (r_state == ST_IDLE)
            r_bitcnt <= '0;
         else if (w_sample)
            r_bitcnt <= (w_next != r_state) ? 7'd0 : r_bitcnt + 7'd1;
         // Unaddressed frames run to EOF silently so busy stays meaningful.
         if (r_state == ST_EOF && w_sample) begin
            if (!w_line) begin
               r_frm_err <= r_match;
            end else if (r_match) begin
               if (r_crc_rx == r_crc_calc) begin
                  r_rx_valid <= 1'b1;
                  rx_addr    <= r_addr;
                  rx_data    <= r_data;
               end else begin
                  r_crc_err  <= 1'b1;
               end
            end
         end
      end
   end

   always_ff @(posedge clock) begin
      if (r_state == ST_IDLE) begin
         r_crc_calc <= '0;
      end else if (w_sample) begin
         case (r_state)
            ST_ADDR: begin
               r_addr     <= w_addr_nx;
               r_crc_calc <= crc4_update(r_crc_calc, w_line);
               if (r_bitcnt == ADDR_LAST)
                  r_match <= (w_addr_nx == my_addr) || (w_addr_nx == BCAST_ADDR);
            end
            ST_DATA: begin
               r_data     <= {r_data[DATA_W-2:0], w_line};
               r_crc_calc <= crc4_update(r_crc_calc, w_line);
            end
            ST_CRC:  r_crc_rx <= {r_crc_rx[CRC_W-2:0], w_line};
            default: ;
         endcase
      end
   end

`ifdef BUS_RX_ACK_EN
   logic [CRC_W-1:0] w_crc_nx;
   logic             w_ack_start;
   logic [7:0]       r_ack_cnt;

   assign w_crc_nx    = {r_crc_rx[CRC_W-2:0], w_line};
   // Drive starts at the last CRC sample, which lines up with the raw ACK bit
   // boundary once the two-flop synchroniser delay is accounted for.
   assign w_ack_start = (r_state == ST_CRC) && w_sample && (r_bitcnt == CRC_LAST) &&
                        r_match && (w_crc_nx == r_crc_calc);

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n)
         r_ack_cnt <= '0;
      else if (w_ack_start)
         r_ack_cnt <= 8'(BIT_CYCLES - 1);
      else if (r_ack_cnt != 8'd0)
         r_ack_cnt <= r_ack_cnt - 8'd1;
   end

   assign bus = (w_ack_start || r_ack_cnt != 8'd0) ? 1'b0 : 1'bz;
`else
   assign bus = 1'bz;
`endif

   assign rx_valid = r_rx_valid;
   assign crc_err  = r_crc_err;
   assign frm_err  = r_frm_err;
   assign busy     = w_busy;

endmodule
